// File: rtl/vga_480_pkg.sv
// Shared timing defaults and coordinate type for the 640x480@60 VGA timing generator.
package vga_480_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int COORD_W  = 10;

    typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/vga_timing_480_if.sv
// Raster output bundle of the VGA timing generator: coordinates, display enable and syncs.
interface vga_timing_480_if;
    import vga_480_pkg::*;

    coord_t o_Sx;
    coord_t o_Sy;
    logic   o_de;
    logic   o_hsync;
    logic   o_vsync;

    modport master (
        output o_Sx,
        output o_Sy,
        output o_de,
        output o_hsync,
        output o_vsync
    );

    modport slave (
        input o_Sx,
        input o_Sy,
        input o_de,
        input o_hsync,
        input o_vsync
    );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with registered active/sync flags
// decoded from the next count so they line up with the registered count.
module vga_axis_counter #(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                step,
    output vga_480_pkg::coord_t count,
    output logic                wrap,
    output logic                active,
    output logic                sync
);
    import vga_480_pkg::*;

    localparam int     TOTAL      = ACTIVE + FP + SYNC + BP;
    localparam coord_t LAST       = coord_t'(TOTAL - 1);
    localparam coord_t ACT_END    = coord_t'(ACTIVE);
    localparam coord_t SYNC_START = coord_t'(ACTIVE + FP);
    localparam coord_t SYNC_END   = coord_t'(ACTIVE + FP + SYNC);

    if (TOTAL > 1024) begin : g_total_check
        $error("vga_axis_counter: axis total %0d exceeds 1024", TOTAL);
    end

    coord_t count_q, count_d;
    logic   active_q, active_d;
    logic   sync_q, sync_d;

    always_comb begin
        wrap     = step && (count_q == LAST);
        count_d  = count_q;
        if (step) begin
            count_d = wrap ? '0 : count_q + coord_t'(1);
        end
        active_d = (count_d < ACT_END);
        sync_d   = (count_d >= SYNC_START) && (count_d < SYNC_END);
    end

    // Reset parks the axis on its last position so the first step lands on 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= LAST;
            active_q <= 1'b0;
            sync_q   <= 1'b0;
        end else begin
            count_q  <= count_d;
            active_q <= active_d;
            sync_q   <= sync_d;
        end
    end

    assign count  = count_q;
    assign active = active_q;
    assign sync   = sync_q;

endmodule

// File: rtl/vga_timing_480.sv
// Free-running 640x480@60 VGA timing generator (horizontal + vertical axis counters).
// Define VGA_SYNC_ACTIVE_HIGH_EN for active-high syncs; default is active-low.
module vga_timing_480 #(
    parameter int H_ACTIVE = vga_480_pkg::H_ACTIVE,
    parameter int H_FP     = vga_480_pkg::H_FP,
    parameter int H_SYNC   = vga_480_pkg::H_SYNC,
    parameter int H_BP     = vga_480_pkg::H_BP,
    parameter int V_ACTIVE = vga_480_pkg::V_ACTIVE,
    parameter int V_FP     = vga_480_pkg::V_FP,
    parameter int V_SYNC   = vga_480_pkg::V_SYNC,
    parameter int V_BP     = vga_480_pkg::V_BP
) (
    input  logic              i_VGA_CLOCK,
    input  logic              i_rst,
    vga_timing_480_if.master  vga
);
    import vga_480_pkg::*;

    coord_t h_count;
    coord_t v_count;
    logic   h_wrap;
    logic   v_wrap_unused;
    logic   h_active;
    logic   v_active;
    logic   h_sync;
    logic   v_sync;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_axis (
        .clk    (i_VGA_CLOCK),
        .rst    (i_rst),
        .step   (1'b1),
        .count  (h_count),
        .wrap   (h_wrap),
        .active (h_active),
        .sync   (h_sync)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_axis (
        .clk    (i_VGA_CLOCK),
        .rst    (i_rst),
        .step   (h_wrap),
        .count  (v_count),
        .wrap   (v_wrap_unused),
        .active (v_active),
        .sync   (v_sync)
    );

    assign vga.o_Sx = h_count;
    assign vga.o_Sy = v_count;
    assign vga.o_de = h_active & v_active;

`ifdef VGA_SYNC_ACTIVE_HIGH_EN
    assign vga.o_hsync = h_sync;
    assign vga.o_vsync = v_sync;
`else
    assign vga.o_hsync = ~h_sync;
    assign vga.o_vsync = ~v_sync;
`endif

endmodule

// File: tb/tb_vga_timing_480.sv
// Scoreboard bench for vga_timing_480: default-timing instance plus a shrunken-timing
// instance so complete frames, vsync and mid-frame reset fit in a short run.
module tb_vga_timing_480;
    import vga_480_pkg::*;

    typedef struct packed {
        logic [9:0] sx;
        logic [9:0] sy;
        logic       de;
        logic       hs;
        logic       vs;
    } obs_t;

    localparam int S_HA = 8, S_HFP = 2, S_HS = 3, S_HBP = 2;
    localparam int S_VA = 6, S_VFP = 1, S_VS = 2, S_VBP = 1;
    localparam int S_HT = S_HA + S_HFP + S_HS + S_HBP;
    localparam int S_VT = S_VA + S_VFP + S_VS + S_VBP;

`ifdef VGA_SYNC_ACTIVE_HIGH_EN
    localparam logic SYNC_ON = 1'b1;
`else
    localparam logic SYNC_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    vga_timing_480_if big_if ();
    vga_timing_480_if small_if ();

    vga_timing_480 u_big (
        .i_VGA_CLOCK (clk),
        .i_rst       (rst),
        .vga         (big_if)
    );

    vga_timing_480 #(
        .H_ACTIVE (S_HA), .H_FP (S_HFP), .H_SYNC (S_HS), .H_BP (S_HBP),
        .V_ACTIVE (S_VA), .V_FP (S_VFP), .V_SYNC (S_VS), .V_BP (S_VBP)
    ) u_small (
        .i_VGA_CLOCK (clk),
        .i_rst       (rst),
        .vga         (small_if)
    );

    always #20 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    obs_t big_q[$];
    obs_t small_q[$];
    int   bx, by, sx, sy;

    function automatic obs_t decode(int x, int y, int ha, int hfp, int hsw,
                                    int va, int vfp, int vsw);
        obs_t o;
        o.sx = 10'(x);
        o.sy = 10'(y);
        o.de = (x < ha) && (y < va);
        o.hs = (x >= ha + hfp && x < ha + hfp + hsw) ? SYNC_ON : ~SYNC_ON;
        o.vs = (y >= va + vfp && y < va + vfp + vsw) ? SYNC_ON : ~SYNC_ON;
        return o;
    endfunction

    function automatic obs_t sample_big();
        return {big_if.o_Sx, big_if.o_Sy, big_if.o_de, big_if.o_hsync, big_if.o_vsync};
    endfunction

    function automatic obs_t sample_small();
        return {small_if.o_Sx, small_if.o_Sy, small_if.o_de, small_if.o_hsync, small_if.o_vsync};
    endfunction

    // Advance the reference raster for one edge, queue what both DUTs must show, then clock.
    task automatic drive_cycle(input logic r);
        rst = r;
        if (r) begin
            bx = H_TOTAL - 1; by = V_TOTAL - 1;
            sx = S_HT - 1;    sy = S_VT - 1;
        end else begin
            if (bx == H_TOTAL - 1) begin
                bx = 0;
                by = (by == V_TOTAL - 1) ? 0 : by + 1;
            end else begin
                bx = bx + 1;
            end
            if (sx == S_HT - 1) begin
                sx = 0;
                sy = (sy == S_VT - 1) ? 0 : sy + 1;
            end else begin
                sx = sx + 1;
            end
        end
        big_q.push_back(decode(bx, by, H_ACTIVE, H_FP, H_SYNC, V_ACTIVE, V_FP, V_SYNC));
        small_q.push_back(decode(sx, sy, S_HA, S_HFP, S_HS, S_VA, S_VFP, S_VS));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t got, exp;
        for (int i = 0; i < 6; i++) begin
            drive_cycle(i < 5);
            got = sample_big(); exp = big_q.pop_front(); checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL reset_big cyc=%0d got=%h exp=%h", i, got, exp);
            end
            got = sample_small(); exp = small_q.pop_front(); checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL reset_small cyc=%0d got=%h exp=%h", i, got, exp);
            end
            if (i == 4) begin
                checks++;
                if (sample_big() !== {10'd799, 10'd524, 1'b0, ~SYNC_ON, ~SYNC_ON}) begin
                    errors++;
                    $display("[TB] FAIL reset_values got=%h", sample_big());
                end
            end
        end
        checks++;
        if ({big_if.o_Sx, big_if.o_Sy, big_if.o_de} !== {10'd0, 10'd0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL release_origin got sx=%0d sy=%0d de=%b exp 0,0,1",
                     big_if.o_Sx, big_if.o_Sy, big_if.o_de);
        end
    endtask

    task automatic test_line();
        obs_t got, exp;
        int   de_cnt = 0;
        int   hs_cnt = 0;
        for (int i = 0; i < H_TOTAL; i++) begin
            drive_cycle(1'b0);
            got = sample_big(); exp = big_q.pop_front(); checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL line_big cyc=%0d got=%h exp=%h", i, got, exp);
            end
            if (got.de === 1'b1) de_cnt++;
            if (got.hs === SYNC_ON) hs_cnt++;
            got = sample_small(); exp = small_q.pop_front(); checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL line_small cyc=%0d got=%h exp=%h", i, got, exp);
            end
        end
        checks++;
        if (de_cnt !== 640) begin
            errors++;
            $display("[TB] FAIL line_de_count got=%0d exp=640", de_cnt);
        end
        checks++;
        if (hs_cnt !== 96) begin
            errors++;
            $display("[TB] FAIL line_hsync_width got=%0d exp=96", hs_cnt);
        end
        checks++;
        if ({big_if.o_Sx, big_if.o_Sy} !== {10'd0, 10'd1}) begin
            errors++;
            $display("[TB] FAIL line_wrap got sx=%0d sy=%0d exp 0,1", big_if.o_Sx, big_if.o_Sy);
        end
    endtask

    task automatic test_small_frame();
        obs_t got, exp;
        int   de_cnt = 0;
        int   vs_cnt = 0;
        int   edges[$];
        logic prev_vs = small_if.o_vsync;
        for (int i = 0; i < 2 * S_HT * S_VT + 30; i++) begin
            drive_cycle(1'b0);
            got = sample_big(); exp = big_q.pop_front(); checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL frame_big cyc=%0d got=%h exp=%h", i, got, exp);
            end
            got = sample_small(); exp = small_q.pop_front(); checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL frame_small cyc=%0d got=%h exp=%h", i, got, exp);
            end
            if (i < S_HT * S_VT) begin
                if (got.de === 1'b1) de_cnt++;
                if (got.vs === SYNC_ON) vs_cnt++;
            end
            if (prev_vs !== SYNC_ON && got.vs === SYNC_ON) edges.push_back(i);
            prev_vs = got.vs;
        end
        checks++;
        if (de_cnt !== S_HA * S_VA) begin
            errors++;
            $display("[TB] FAIL frame_de_count got=%0d exp=%0d", de_cnt, S_HA * S_VA);
        end
        checks++;
        if (vs_cnt !== S_VS * S_HT) begin
            errors++;
            $display("[TB] FAIL frame_vsync_width got=%0d exp=%0d", vs_cnt, S_VS * S_HT);
        end
        checks++;
        if (edges.size() < 2) begin
            errors++;
            $display("[TB] FAIL vsync_period got %0d edges exp >=2", edges.size());
        end else if (edges[1] - edges[0] !== S_HT * S_VT) begin
            errors++;
            $display("[TB] FAIL vsync_period got=%0d exp=%0d", edges[1] - edges[0], S_HT * S_VT);
        end
    endtask

    task automatic test_mid_reset();
        obs_t got, exp;
        int   budget = 0;
        while (bx != 300 && budget < 2000) begin
            drive_cycle(1'b0);
            got = sample_big(); exp = big_q.pop_front(); checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL run_big cyc=%0d got=%h exp=%h", budget, got, exp);
            end
            void'(small_q.pop_front());
            budget++;
        end
        checks++;
        if (big_if.o_Sx !== 10'd300) begin
            errors++;
            $display("[TB] FAIL reach_sx300 got=%0d exp=300", big_if.o_Sx);
        end
        for (int i = 0; i < 2; i++) begin
            drive_cycle(i == 0);
            got = sample_big(); exp = big_q.pop_front(); checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL midrst_big cyc=%0d got=%h exp=%h", i, got, exp);
            end
            got = sample_small(); exp = small_q.pop_front(); checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL midrst_small cyc=%0d got=%h exp=%h", i, got, exp);
            end
        end
        checks++;
        if ({big_if.o_Sx, big_if.o_Sy, big_if.o_de} !== {10'd0, 10'd0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL midrst_origin got sx=%0d sy=%0d de=%b exp 0,0,1",
                     big_if.o_Sx, big_if.o_Sy, big_if.o_de);
        end
    endtask

    initial begin
        $display("[TB] vga_timing_480 bench start, sync active level %b", SYNC_ON);
        test_reset();
        test_line();
        test_small_frame();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
